// File: rtl/key_calc_ctrl.sv
// Keyboard entry sequencer for two 2-digit operands and an operator, with a
// 14-step double-dabble engine that converts the result for the 4-digit display.
module key_calc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] N2,
    output logic [3:0] N1,
    output logic [3:0] S1,
    output logic [3:0] S0,
    output logic [2:0] mark,
    output logic       busy
);
    localparam int unsigned OPD_W = 7;
    localparam int unsigned BIN_W = 14;
    localparam int unsigned BCD_W = 16;
    localparam int unsigned ITERS = 14;

    typedef enum logic [1:0] {ENT_A, ENT_B, CONV, RESULT} state_t;

    state_t                state;
    logic [1:0]            cnt_a;
    logic [1:0]            cnt_b;
    logic [3:0]            iter;
    logic [BIN_W-1:0]      bin;
    logic [BCD_W-1:0]      bcd;
    logic                  neg;

    logic                  is_digit_c;
    logic                  is_op_c;
    logic                  is_enter_c;
    logic                  is_clear_c;
    logic [OPD_W-1:0]      a_val_c;
    logic [OPD_W-1:0]      b_val_c;
    logic [BIN_W-1:0]      res_c;
    logic                  res_neg_c;
    logic [BCD_W-1:0]      adj_c;
    logic [BCD_W+BIN_W-1:0] dd_nxt_c;

    // Key decode and operand values from the displayed digits
    always_comb begin
        is_digit_c = key_valid && (key_code <= 4'd9);
        is_op_c    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd12);
        is_enter_c = key_valid && (key_code == 4'd13);
        is_clear_c = key_valid && (key_code == 4'd14);
        a_val_c    = OPD_W'(N2) * OPD_W'(10) + OPD_W'(N1);
        b_val_c    = OPD_W'(S1) * OPD_W'(10) + OPD_W'(S0);
    end

    // Result magnitude and sign for the current operator
    always_comb begin
        res_c     = '0;
        res_neg_c = 1'b0;
        case (mark)
            3'd1: res_c = BIN_W'(a_val_c) + BIN_W'(b_val_c);
            3'd2: begin
                res_neg_c = (a_val_c < b_val_c);
                res_c     = res_neg_c ? BIN_W'(b_val_c - a_val_c)
                                      : BIN_W'(a_val_c - b_val_c);
            end
            3'd3: res_c = BIN_W'(a_val_c) * BIN_W'(b_val_c);
            default: res_c = '0;
        endcase
    end

    // One double-dabble step: add-3 to nibbles >= 5, then shift left
    always_comb begin
        adj_c = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        dd_nxt_c = (BCD_W+BIN_W)'({adj_c, bin} << 1);
    end

    always_ff @(posedge clk) begin
        if (rst || is_clear_c) begin
            state <= ENT_A;
            N2    <= '0;
            N1    <= '0;
            S1    <= '0;
            S0    <= '0;
            mark  <= '0;
            busy  <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
            iter  <= '0;
            bin   <= '0;
            bcd   <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                ENT_A: begin
                    if (is_digit_c && cnt_a < 2'd2) begin
                        N2    <= N1;
                        N1    <= key_code;
                        cnt_a <= cnt_a + 2'd1;
                    end else if (is_op_c) begin
                        mark  <= 3'(key_code - 4'd9);
                        state <= ENT_B;
                    end
                end
                ENT_B: begin
                    if (is_digit_c && cnt_b < 2'd2) begin
                        S1    <= S0;
                        S0    <= key_code;
                        cnt_b <= cnt_b + 2'd1;
                    end else if (is_op_c && cnt_b == 2'd0) begin
                        mark  <= 3'(key_code - 4'd9);
                    end else if (is_enter_c && cnt_b != 2'd0) begin
                        bin   <= res_c;
                        neg   <= res_neg_c;
                        bcd   <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    // Keys other than clear are dropped while converting
                    if (iter == 4'(ITERS)) begin
                        N2    <= bcd[15:12];
                        N1    <= bcd[11:8];
                        S1    <= bcd[7:4];
                        S0    <= bcd[3:0];
                        mark  <= neg ? 3'd5 : 3'd4;
                        busy  <= 1'b0;
                        state <= RESULT;
                    end else begin
                        bcd  <= dd_nxt_c[BCD_W+BIN_W-1:BIN_W];
                        bin  <= dd_nxt_c[BIN_W-1:0];
                        iter <= iter + 4'd1;
                    end
                end
                RESULT: begin
                    if (is_digit_c) begin
                        N2    <= '0;
                        N1    <= key_code;
                        S1    <= '0;
                        S0    <= '0;
                        mark  <= '0;
                        cnt_a <= 2'd1;
                        cnt_b <= '0;
                        state <= ENT_A;
                    end
                end
                default: state <= ENT_A;
            endcase
        end
    end
endmodule

// File: tb/tb_key_calc_ctrl.sv
// Randomized and directed bench for key_calc_ctrl against an arithmetic model.
module tb_key_calc_ctrl;
    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] N2, N1, S1, S0;
    logic [2:0] mark;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    key_calc_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .N2(N2), .N1(N1), .S1(S1), .S0(S0), .mark(mark), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: operands as integers, result as integer, countdown for conversion
    int m_mode;   // 0 entering A, 1 entering B, 2 converting, 3 showing result
    int m_a, m_b, m_acnt, m_bcnt, m_mark, m_left, m_res;
    bit m_neg;

    task automatic model_clear();
        m_mode = 0; m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0;
        m_mark = 0; m_left = 0; m_res = 0; m_neg = 0;
    endtask

    initial model_clear();

    always @(posedge clk) begin
        int c;
        c = int'(key_code);
        if (rst || (key_valid && c == 14)) begin
            model_clear();
        end else if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = 3;
                m_mark = m_neg ? 5 : 4;
            end
        end else if (key_valid) begin
            case (m_mode)
                0: begin
                    if (c <= 9) begin
                        if (m_acnt < 2) begin m_a = (m_a % 10) * 10 + c; m_acnt++; end
                    end else if (c >= 10 && c <= 12) begin
                        m_mark = c - 9; m_mode = 1;
                    end
                end
                1: begin
                    if (c <= 9) begin
                        if (m_bcnt < 2) begin m_b = (m_b % 10) * 10 + c; m_bcnt++; end
                    end else if (c >= 10 && c <= 12) begin
                        if (m_bcnt == 0) m_mark = c - 9;
                    end else if (c == 13 && m_bcnt > 0) begin
                        m_neg = 0;
                        if (m_mark == 1) m_res = m_a + m_b;
                        else if (m_mark == 2) begin
                            m_neg = (m_a < m_b);
                            m_res = m_neg ? m_b - m_a : m_a - m_b;
                        end else m_res = m_a * m_b;
                        m_mode = 2; m_left = 15;
                    end
                end
                3: begin
                    if (c <= 9) begin
                        m_a = c; m_acnt = 1; m_b = 0; m_bcnt = 0; m_mark = 0; m_mode = 0;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic int exp_digit(int idx);
        int v;
        if (m_mode == 3) begin
            v = m_res;
            for (int i = 0; i < idx; i++) v = v / 10;
            return v % 10;
        end
        case (idx)
            3: return m_a / 10;
            2: return m_a % 10;
            1: return m_b / 10;
            default: return m_b % 10;
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("N2", int'(N2), exp_digit(3));
            chk("N1", int'(N1), exp_digit(2));
            chk("S1", int'(S1), exp_digit(1));
            chk("S0", int'(S0), exp_digit(0));
            chk("mark", int'(mark), m_mark);
            chk("busy", int'(busy), (m_mode == 2) ? 1 : 0);
        end
    end

    task automatic cyc(input logic v, input logic [3:0] c);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        #1;
        key_valid = 0;
    endtask

    task automatic key(input int c);
        cyc(1'b1, 4'(c));
    endtask

    task automatic do_rst();
        rst = 1; key_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin cyc(1'b0, 4'd0); n++; end
        chk("wait_idle_bound", int'(busy), 0);
    endtask

    task automatic expect_disp(input string name, input int n2, input int n1,
                               input int s1, input int s0, input int mk, input int bz);
        chk({name, ".N2"}, int'(N2), n2);
        chk({name, ".N1"}, int'(N1), n1);
        chk({name, ".S1"}, int'(S1), s1);
        chk({name, ".S0"}, int'(S0), s0);
        chk({name, ".mark"}, int'(mark), mk);
        chk({name, ".busy"}, int'(busy), bz);
    endtask

    initial begin
        int nb, r;
        rst = 1; key_valid = 0; key_code = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
        expect_disp("reset", 0, 0, 0, 0, 0, 0);
        rst = 0;

        // 12 + 34, with exact busy length
        key(1); key(2); key(10); key(3); key(4); key(13);
        nb = 0;
        while (busy && nb < 40) begin nb++; cyc(1'b0, 4'd0); end
        chk("busy_cycles", nb, 15);
        expect_disp("add", 0, 0, 4, 6, 4, 0);

        // 07 - 25, then 9 * 9 starting from the result
        key(0); key(7); key(11); key(2); key(5); key(13); wait_idle();
        expect_disp("sub_neg", 0, 0, 1, 8, 5, 0);
        key(9); key(12); key(9); key(13); wait_idle();
        expect_disp("mul_small", 0, 0, 8, 1, 4, 0);

        // 99 * 99 and third-digit drop
        key(9); key(9); key(12); key(9); key(9); key(13); wait_idle();
        expect_disp("mul_max", 9, 8, 0, 1, 4, 0);
        key(1); key(2); key(3);
        expect_disp("extra_digit", 1, 2, 0, 0, 0, 0);

        // operator replace and premature enter
        key(14); key(5); key(10); key(13);
        expect_disp("early_enter", 0, 5, 0, 0, 1, 0);
        key(12); key(4); key(13); wait_idle();
        expect_disp("op_replace", 0, 0, 2, 0, 4, 0);

        // keys dropped during conversion, then clear mid-conversion
        key(14); key(1); key(2); key(10); key(3); key(4); key(13);
        cyc(1'b0, 0); cyc(1'b0, 0); key(4); cyc(1'b0, 0); key(10);
        wait_idle();
        expect_disp("drop_in_conv", 0, 0, 4, 6, 4, 0);
        key(14); key(1); key(2); key(10); key(3); key(4); key(13);
        for (int i = 0; i < 6; i++) cyc(1'b0, 0);
        chk("pre_clear_busy", int'(busy), 1);
        key(14);
        expect_disp("clear_conv", 0, 0, 0, 0, 0, 0);

        // reset mid-entry
        key(3); key(11); key(8);
        do_rst();
        expect_disp("rst_mid", 0, 0, 0, 0, 0, 0);
        key(2); key(13);
        expect_disp("enter_in_a", 0, 2, 0, 0, 0, 0);
        key(10); key(1); key(13); wait_idle();
        expect_disp("after_rst", 0, 0, 0, 3, 4, 0);

        // randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_rst();
            end else if ($urandom_range(0, 99) < 45) begin
                r = $urandom_range(0, 99);
                if (r < 55)      key($urandom_range(0, 9));
                else if (r < 70) key($urandom_range(10, 12));
                else if (r < 89) key(13);
                else if (r < 91) key(14);
                else             key(15);
            end else begin
                cyc(1'b0, 4'($urandom_range(0, 15)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/key_calc_ctrl.md
# key_calc_ctrl

Keyboard-driven entry sequencer and result scheduler for the four-digit VGA/seven-segment display path. It consumes decoded key events and sequences the entry of two 2-digit decimal operands and an operator. On enter it computes the result and converts it to BCD with a multi-cycle double-dabble engine. It then drives the four display digits (N2, N1, S1, S0) and the `mark` symbol code that feed pixel_gen and the ssd instances.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- clk  in  1  system clock; the 100 MHz board clock.
- rst  in  1  synchronous reset, active-high.
- key_valid  in  1  one-cycle pulse: key_code is valid this cycle.
- key_code  in  4  0–9 = digit, 10 = '+', 11 = '-', 12 = '*', 13 = enter, 14 = clear, 15 = ignored.
- N2  out  4  display digit 3, the leftmost (BCD).
- N1  out  4  display digit 2 (BCD).
- S1  out  4  display digit 1 (BCD).
- S0  out  4  display digit 0, the rightmost (BCD).
- mark  out  3  symbol code: 0 = none, 1 = '+', 2 = '-', 3 = '*', 4 = '=' (result ≥ 0), 5 = '=' (negative result, magnitude shown).
- busy  out  1  high while BCD conversion runs.

## Operation
States: ENT_A, ENT_B, CONV, RESULT. Reset and clear both enter ENT_A with all digits at 0, mark = 0, busy = 0 and digit counts at 0.

ENT_A:
- digit d: if cntA < 2, then N2 ← N1, N1 ← d, cntA++. Otherwise the key is ignored (operands are at most 2 digits).
- operator: mark ← 1/2/3, go to ENT_B. This is also allowed when cntA = 0, giving A = 0.
- enter: ignored.

ENT_B:
- digit: shifts into S1:S0 under the same rule, using cntB.
- operator: if cntB = 0, replaces mark. Otherwise ignored.
- enter: if cntB = 0, ignored. Otherwise compute the result and go to CONV.

Compute, in the accept cycle:
- A = 10·N2 + N1 and B = 10·S1 + S0, each 7-bit unsigned.
- '+': R = A + B, range 0..198.
- '-': R = A − B, signed. neg = (A < B); magnitude = |A − B|.
- '*': R = A·B, range 0..9801.
- The 14-bit magnitude and neg are latched for the conversion.

CONV:
- Iterative double-dabble, one shift per cycle, 14 iterations.
- Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left one bit.
- On completion, the digits are written to N2 N1 S1 S0 with leading zeros kept, mark ← (neg ? 5 : 4), and the state goes to RESULT.
- Entry digits stay displayed unchanged during CONV.

RESULT:
- digit d: start a new A. N2 ← 0, N1 ← d, S1 = S0 = 0, mark ← 0, cntA ← 1, cntB ← 0, go to ENT_A.
- operator or enter: ignored.

Clear (code 14):
- Accepted in every state, including CONV. It aborts conversion and the partial result is discarded.

Code 15 is ignored in all states. All other keys arriving while busy = 1 are dropped; there is no queueing.

## Timing
- All outputs are registered.
- Reset values: N2 = N1 = S1 = S0 = 0, mark = 0, busy = 0.
- Digit, operator and clear keys take effect at the clock edge that samples key_valid = 1; the outputs show the new value in the next cycle.
- Enter accepted at edge k:
  - busy = 1 after edges k through k+14, which is 15 cycles.
  - At edge k+15, the digits and mark update and busy ← 0.
  - The result is therefore visible, with busy low, in the first cycle after edge k+15.
- A key is accepted at the same edge at which busy falls only if the state is already RESULT; keys arriving in that last busy cycle are dropped.
- Clear or rst in any cycle, including mid-CONV, forces the reset values at that edge.
- key_valid must be a single-cycle pulse. If it is held high for several cycles, each cycle counts as a separate key.

## Test plan
- Keys 1,2,'+',3,4,enter → busy high for exactly 15 cycles; then N2..S0 = 0,0,4,6 and mark = 4.
- Keys 0,7,'-',2,5,enter → digits 0,0,1,8 and mark = 5. Then 9,'*',9,enter → digits 0,0,8,1 and mark = 4.
- Keys 9,9,'*',9,9,enter → digits 9,8,0,1 and mark = 4. Extra digit: 1,2,3 in ENT_A → N2 = 1, N1 = 2, with 3 ignored.
- Operator replace: 5,'+','*',4,enter → result 0,0,2,0. Enter pressed with no B digits → no state change, busy stays 0.
- Keys 4 and '+' pulsed during CONV → dropped, and the result is unaffected. Clear pulsed at cycle 7 of CONV → all outputs 0 at the next cycle and busy = 0.
- rst asserted mid-entry (after 3,'-',8) → all outputs 0. Then 2,enter → ignored; then '+',1,enter → result 0,0,0,3.
